decode_dispatch_scheduler: RTL and testbench

//  Sits between the two per-thread fetch streams and decode stage 1 (Format_Decoder).

---
 rtl/decode_dispatch_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_decode_dispatch_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/decode_dispatch_scheduler.sv
// Two per-thread fetch FIFOs feeding decode stage 1 with round-robin pick and major-ID stamping.
// Optional DISPATCH_PERF_COUNTERS_EN adds saturating stall/empty cycle counters.
module decode_dispatch_scheduler #(
    parameter int unsigned addressWidth            = 64,
    parameter int unsigned instructionWidth        = 32,
    parameter int unsigned PidSize                 = 20,
    parameter int unsigned TidSize                 = 16,
    parameter int unsigned instructionCounterWidth = 64,
    parameter int unsigned fifoDepthLog2           = 2
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               stall_i,
    input  logic                               fetchValid0_i,
    output logic                               fetchReady0_o,
    input  logic [instructionWidth-1:0]        fetchInst0_i,
    input  logic [addressWidth-1:0]            fetchAddr0_i,
    input  logic [PidSize-1:0]                 fetchPid0_i,
    input  logic [TidSize-1:0]                 fetchTid0_i,
    input  logic                               flush0_i,
    input  logic                               fetchValid1_i,
    output logic                               fetchReady1_o,
    input  logic [instructionWidth-1:0]        fetchInst1_i,
    input  logic [addressWidth-1:0]            fetchAddr1_i,
    input  logic [PidSize-1:0]                 fetchPid1_i,
    input  logic [TidSize-1:0]                 fetchTid1_i,
    input  logic                               flush1_i,
    output logic                               enable_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
    output logic [instructionCounterWidth-1:0] instructionMajId_o,
    output logic                               outPort_o
`ifdef DISPATCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]                        stallCycles_o,
    output logic [31:0]                        emptyCycles_o
`endif
);

    localparam int unsigned DEPTH = 1 << fifoDepthLog2;
    localparam int unsigned EW    = instructionWidth + addressWidth + PidSize + TidSize;

    typedef logic [fifoDepthLog2-1:0] ptr_t;
    typedef logic [fifoDepthLog2:0]   cnt_t;

    logic [EW-1:0] entryIn [2];
    logic [EW-1:0] head    [2];
    logic [1:0]    valid, flush, full, empty, push, pop, avail;

    assign entryIn[0] = {fetchInst0_i, fetchAddr0_i, fetchPid0_i, fetchTid0_i};
    assign entryIn[1] = {fetchInst1_i, fetchAddr1_i, fetchPid1_i, fetchTid1_i};
    assign valid      = {fetchValid1_i, fetchValid0_i};
    assign flush      = {flush1_i, flush0_i};
    assign fetchReady0_o = ~full[0];
    assign fetchReady1_o = ~full[1];

    for (genvar p = 0; p < 2; p++) begin : g_fifo
        logic [EW-1:0] mem_q [DEPTH];
        ptr_t wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
        cnt_t count_q, count_d;

        always_comb begin
            full[p]  = (count_q == cnt_t'(DEPTH));
            empty[p] = (count_q == '0);
            // flush drops a same-cycle push and hides the FIFO from arbitration
            push[p]  = valid[p] & ~full[p] & ~flush[p];
            avail[p] = ~empty[p] & ~flush[p];
            head[p]  = mem_q[rdPtr_q];
            wrPtr_d  = wrPtr_q;
            rdPtr_d  = rdPtr_q;
            count_d  = count_q;
            if (flush[p]) begin
                wrPtr_d = '0;
                rdPtr_d = '0;
                count_d = '0;
            end else begin
                wrPtr_d = wrPtr_q + ptr_t'(push[p]);
                rdPtr_d = rdPtr_q + ptr_t'(pop[p]);
                count_d = count_q + cnt_t'(push[p]) - cnt_t'(pop[p]);
            end
        end

        always_ff @(posedge clock_i) begin
            if (!reset_i) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
                count_q <= '0;
            end else begin
                wrPtr_q <= wrPtr_d;
                rdPtr_q <= rdPtr_d;
                count_q <= count_d;
            end
        end

        always_ff @(posedge clock_i) begin
            if (push[p]) mem_q[wrPtr_q] <= entryIn[p];
        end
    end

    logic                               enable_q, enable_d;
    logic [EW-1:0]                      data_q, data_d;
    logic [instructionCounterWidth-1:0] majId_q, majId_d;
    logic [instructionCounterWidth-1:0] majCnt_q, majCnt_d;
    logic                               outPort_q, outPort_d;
    logic                               prefer_q, prefer_d;
    logic                               grant, winner;

    always_comb begin
        grant  = ~stall_i & (avail[0] | avail[1]);
        winner = (avail[0] & avail[1]) ? prefer_q : avail[1];
        pop    = '0;
        if (grant) pop[winner] = 1'b1;

        enable_d  = enable_q;
        data_d    = data_q;
        majId_d   = majId_q;
        majCnt_d  = majCnt_q;
        outPort_d = outPort_q;
        prefer_d  = prefer_q;
        if (!stall_i) begin
            enable_d = grant;
            if (grant) begin
                data_d    = head[winner];
                majId_d   = majCnt_q;
                majCnt_d  = majCnt_q + 1'b1;
                outPort_d = winner;
                prefer_d  = ~winner;
            end
        end else if (enable_q && flush[outPort_q]) begin
            // a held slot from a flushed port is invalidated even under stall
            enable_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            enable_q  <= 1'b0;
            data_q    <= '0;
            majId_q   <= '0;
            majCnt_q  <= '0;
            outPort_q <= 1'b0;
            prefer_q  <= 1'b0;
        end else begin
            enable_q  <= enable_d;
            data_q    <= data_d;
            majId_q   <= majId_d;
            majCnt_q  <= majCnt_d;
            outPort_q <= outPort_d;
            prefer_q  <= prefer_d;
        end
    end

    assign enable_o           = enable_q;
    assign {instruction_o, instructionAddress_o, instructionPid_o, instructionTid_o} = data_q;
    assign instructionMajId_o = majId_q;
    assign outPort_o          = outPort_q;

`ifdef DISPATCH_PERF_COUNTERS_EN
    logic [31:0] stallCnt_q, stallCnt_d, emptyCnt_q, emptyCnt_d;

    always_comb begin
        stallCnt_d = stallCnt_q;
        emptyCnt_d = emptyCnt_q;
        if (stall_i && enable_q && stallCnt_q != '1) stallCnt_d = stallCnt_q + 1'b1;
        if (!stall_i && empty[0] && empty[1] && emptyCnt_q != '1) emptyCnt_d = emptyCnt_q + 1'b1;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            stallCnt_q <= '0;
            emptyCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            emptyCnt_q <= emptyCnt_d;
        end
    end

    assign stallCycles_o = stallCnt_q;
    assign emptyCycles_o = emptyCnt_q;
`endif

endmodule

// File: tb/tb_decode_dispatch_scheduler.sv
// Directed bench for decode_dispatch_scheduler: reset, latency, round-robin, stall, flush, ID wrap.
module tb_decode_dispatch_scheduler;

    logic        clk = 1'b0;
    logic        reset_n, stall;
    logic        v0, v1, f0, f1, rdy0, rdy1;
    logic [31:0] inst0, inst1;
    logic [63:0] addr0, addr1;
    logic [19:0] pid0, pid1;
    logic [15:0] tid0, tid1;
    logic        en, oport;
    logic [31:0] inst;
    logic [63:0] addr, maj;
    logic [19:0] pid;
    logic [15:0] tid;
`ifdef DISPATCH_PERF_COUNTERS_EN
    logic [31:0] stallCyc, emptyCyc;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_dispatch_scheduler #(
        .addressWidth(64), .instructionWidth(32), .PidSize(20), .TidSize(16),
        .instructionCounterWidth(64), .fifoDepthLog2(2)
    ) dut (
        .clock_i(clk), .reset_i(reset_n), .stall_i(stall),
        .fetchValid0_i(v0), .fetchReady0_o(rdy0), .fetchInst0_i(inst0), .fetchAddr0_i(addr0),
        .fetchPid0_i(pid0), .fetchTid0_i(tid0), .flush0_i(f0),
        .fetchValid1_i(v1), .fetchReady1_o(rdy1), .fetchInst1_i(inst1), .fetchAddr1_i(addr1),
        .fetchPid1_i(pid1), .fetchTid1_i(tid1), .flush1_i(f1),
        .enable_o(en), .instruction_o(inst), .instructionAddress_o(addr),
        .instructionPid_o(pid), .instructionTid_o(tid), .instructionMajId_o(maj),
        .outPort_o(oport)
`ifdef DISPATCH_PERF_COUNTERS_EN
        , .stallCycles_o(stallCyc), .emptyCycles_o(emptyCyc)
`endif
    );

    task step();
        @(negedge clk);
    endtask

    task clear_inputs();
        stall = 0; v0 = 0; v1 = 0; f0 = 0; f1 = 0;
        inst0 = '0; inst1 = '0; addr0 = '0; addr1 = '0;
        pid0 = '0; pid1 = '0; tid0 = '0; tid1 = '0;
    endtask

    task do_reset();
        clear_inputs();
        reset_n = 0;
        step();
        step();
        reset_n = 1;
    endtask

    task test_reset();
        do_reset();
        reset_n = 0;
        step();
        total++; if (en !== 1'b0) begin bad++; $display("FAIL reset_en got=%0b want=0", en); end
        total++; if (maj !== 64'd0) begin bad++; $display("FAIL reset_maj got=%0h want=0", maj); end
        total++; if (inst !== 32'd0) begin bad++; $display("FAIL reset_inst got=%0h want=0", inst); end
        total++; if (oport !== 1'b0) begin bad++; $display("FAIL reset_port got=%0b want=0", oport); end
        reset_n = 1;
        step();
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL reset_rdy0 got=%0b want=1", rdy0); end
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL reset_rdy1 got=%0b want=1", rdy1); end
    endtask

    task test_single();
        v0 = 1; inst0 = 32'h4800_0000; addr0 = 64'h1000; pid0 = 20'h12345; tid0 = 16'h0042;
        step();
        v0 = 0;
        total++; if (en !== 1'b0) begin bad++; $display("FAIL single_latency got=%0b want=0", en); end
        step();
        total++; if (en !== 1'b1) begin bad++; $display("FAIL single_en got=%0b want=1", en); end
        total++; if (inst !== 32'h4800_0000) begin bad++; $display("FAIL single_inst got=%0h want=48000000", inst); end
        total++; if (addr !== 64'h1000) begin bad++; $display("FAIL single_addr got=%0h want=1000", addr); end
        total++; if (pid !== 20'h12345 || tid !== 16'h0042) begin bad++; $display("FAIL single_pidtid got=%0h/%0h want=12345/42", pid, tid); end
        total++; if (maj !== 64'd0) begin bad++; $display("FAIL single_maj got=%0h want=0", maj); end
        total++; if (oport !== 1'b0) begin bad++; $display("FAIL single_port got=%0b want=0", oport); end
        step();
        total++; if (en !== 1'b0) begin bad++; $display("FAIL single_drain_en got=%0b want=0", en); end
        total++; if (inst !== 32'h4800_0000) begin bad++; $display("FAIL single_hold_inst got=%0h want=48000000", inst); end
    endtask

    task test_fill_rr();
        logic [31:0] want;
        do_reset();
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            v0 = 1; inst0 = 32'h100 + i;
            v1 = 1; inst1 = 32'h200 + i;
            step();
        end
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL fill_rdy0 got=%0b want=0", rdy0); end
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL fill_rdy1 got=%0b want=0", rdy1); end
        v1 = 0; inst0 = 32'hDEAD;
        step();
        v0 = 0; stall = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            want = ((k % 2) != 0) ? 32'h200 + k / 2 : 32'h100 + k / 2;
            total++; if (en !== 1'b1) begin bad++; $display("FAIL rr_en[%0d] got=%0b want=1", k, en); end
            total++; if (oport !== 1'(k % 2)) begin bad++; $display("FAIL rr_port[%0d] got=%0b want=%0d", k, oport, k % 2); end
            total++; if (inst !== want) begin bad++; $display("FAIL rr_inst[%0d] got=%0h want=%0h", k, inst, want); end
            total++; if (maj !== 64'(k)) begin bad++; $display("FAIL rr_maj[%0d] got=%0h want=%0h", k, maj, k); end
        end
        step();
        total++; if (en !== 1'b0) begin bad++; $display("FAIL rr_drain_en got=%0b want=0", en); end
    endtask

    task test_stall();
        v0 = 1; inst0 = 32'h300;
        step();
        v0 = 0;
        step();
        total++; if (en !== 1'b1 || inst !== 32'h300 || maj !== 64'd8) begin
            bad++; $display("FAIL stall_pre got=%0b/%0h/%0h want=1/300/8", en, inst, maj); end
        stall = 1; v0 = 1; inst0 = 32'h301; v1 = 1; inst1 = 32'h400;
        for (int i = 0; i < 3; i++) begin
            step();
            v0 = 0; v1 = 0;
            total++; if (en !== 1'b1 || inst !== 32'h300 || maj !== 64'd8 || oport !== 1'b0) begin
                bad++; $display("FAIL stall_hold[%0d] got=%0b/%0h/%0h/%0b want=1/300/8/0", i, en, inst, maj, oport); end
        end
        stall = 0;
        step();
        total++; if (en !== 1'b1 || inst !== 32'h400 || maj !== 64'd9 || oport !== 1'b1) begin
            bad++; $display("FAIL stall_resume1 got=%0b/%0h/%0h/%0b want=1/400/9/1", en, inst, maj, oport); end
        step();
        total++; if (en !== 1'b1 || inst !== 32'h301 || maj !== 64'd10 || oport !== 1'b0) begin
            bad++; $display("FAIL stall_resume2 got=%0b/%0h/%0h/%0b want=1/301/a/0", en, inst, maj, oport); end
        step();
        total++; if (en !== 1'b0 || maj !== 64'd10) begin
            bad++; $display("FAIL stall_drain got=%0b/%0h want=0/a", en, maj); end
    endtask

    task test_flush();
        stall = 1; v0 = 1; inst0 = 32'h600; v1 = 1; inst1 = 32'h500;
        step();
        inst0 = 32'h601; v1 = 0;
        step();
        v0 = 0; stall = 0;
        step();
        total++; if (en !== 1'b1 || inst !== 32'h500 || maj !== 64'd11 || oport !== 1'b1) begin
            bad++; $display("FAIL flush_pre got=%0b/%0h/%0h/%0b want=1/500/b/1", en, inst, maj, oport); end
        stall = 1; f1 = 1; v1 = 1; inst1 = 32'h777;
        step();
        f1 = 0; v1 = 0;
        total++; if (en !== 1'b0) begin bad++; $display("FAIL flush_en got=%0b want=0", en); end
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL flush_rdy1 got=%0b want=1", rdy1); end
        stall = 0;
        step();
        total++; if (en !== 1'b1 || inst !== 32'h600 || maj !== 64'd12 || oport !== 1'b0) begin
            bad++; $display("FAIL flush_post1 got=%0b/%0h/%0h/%0b want=1/600/c/0", en, inst, maj, oport); end
        step();
        total++; if (en !== 1'b1 || inst !== 32'h601 || maj !== 64'd13 || oport !== 1'b0) begin
            bad++; $display("FAIL flush_post2 got=%0b/%0h/%0h/%0b want=1/601/d/0", en, inst, maj, oport); end
        step();
        total++; if (en !== 1'b0) begin bad++; $display("FAIL flush_drain got=%0b want=0", en); end
    endtask

    task test_wrap();
        stall = 1;
        force dut.majCnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        v0 = 1; inst0 = 32'hA0;
        step();
        inst0 = 32'hA1;
        step();
        v0 = 0;
        release dut.majCnt_q;
        stall = 0;
        step();
        total++; if (en !== 1'b1 || inst !== 32'hA0 || maj !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++; $display("FAIL wrap_max got=%0b/%0h/%0h want=1/a0/ffffffffffffffff", en, inst, maj); end
        step();
        total++; if (en !== 1'b1 || inst !== 32'hA1 || maj !== 64'd0) begin
            bad++; $display("FAIL wrap_zero got=%0b/%0h/%0h want=1/a1/0", en, inst, maj); end
    endtask

    initial begin
        clear_inputs();
        reset_n = 0;
        test_reset();
        test_single();
        test_fill_rr();
        test_stall();
        test_flush();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
